sm_control_unit: RTL and testbench

- Fetch/decode/sequence controller for one SM; the block directly upstream of SPCore.
- Fetches 32-bit instructions from instruction memory, decodes them and drives the shared SPCore control bus (x, y, z, I, aluc, s2, reg_we, en) plus the data-memory write strobe.
- One instance broadcasts to all SPCores of the SM (SIMD); per-core results stay in the cores.

---
 rtl/sm_control_unit.sv | 149 ++++++++++++++
 tb/tb_sm_control_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_control_unit.sv
// rtl/sm_control_unit.sv - SM fetch/decode/sequence controller driving the shared SPCore control bus
// Optional feature macro: SM_BRANCH_EN (adds BRA/BRP; otherwise ops 11/12 run as NOP and p_in is unused).
`ifndef ALUC_NONE
`define ALUC_NONE    4'd0
`define ALUC_ADD     4'd1
`define ALUC_MUL     4'd2
`define ALUC_MAD     4'd3
`define ALUC_CORE_ID 4'd4
`define ALUC_CLEAR   4'd5
`define ALUC_INC     4'd6
`define ALUC_EQ      4'd7
`endif
`ifndef MuxD_fromALU
`define MuxD_fromALU 2'd0
`define MuxD_fromI   2'd1
`define MuxD_fromMem 2'd2
`endif

module sm_control_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [3:0]             x,
    output logic [3:0]             y,
    output logic [3:0]             z,
    output logic [15:0]            I,
    output logic [3:0]             aluc,
    output logic [1:0]             s2,
    output logic                   reg_we,
    output logic                   en,
    output logic                   mem_we,
    input  logic                   p_in,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_LOADI = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MAD   = 4'd4;
    localparam logic [3:0] OP_LOADC = 4'd5;
    localparam logic [3:0] OP_CLEAR = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_SETP  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_HALT  = 4'd15;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
    logic [3:0]              op;
    logic [3:0]              aluc_c;
    logic [1:0]              s2_c;
    logic                    writes_reg;
    logic                    take_branch;

    assign op = ir_q[31:28];

`ifdef SM_BRANCH_EN
    localparam logic [3:0] OP_BRA = 4'd11;
    localparam logic [3:0] OP_BRP = 4'd12;
    assign take_branch = (op == OP_BRA) || ((op == OP_BRP) && p_in);
`else
    logic unused_p_in;
    assign take_branch = 1'b0;
    assign unused_p_in = p_in;
`endif

    // Bus fields come straight from IR, so they hold steady from EXE through WB.
    always_comb begin
        aluc_c     = `ALUC_NONE;
        s2_c       = `MuxD_fromALU;
        writes_reg = 1'b0;
        case (op)
            OP_LOADI: begin s2_c = `MuxD_fromI; writes_reg = 1'b1; end
            OP_ADD:   begin aluc_c = `ALUC_ADD;     writes_reg = 1'b1; end
            OP_MUL:   begin aluc_c = `ALUC_MUL;     writes_reg = 1'b1; end
            OP_MAD:   begin aluc_c = `ALUC_MAD;     writes_reg = 1'b1; end
            OP_LOADC: begin aluc_c = `ALUC_CORE_ID; writes_reg = 1'b1; end
            OP_CLEAR: begin aluc_c = `ALUC_CLEAR;   writes_reg = 1'b1; end
            OP_INC:   begin aluc_c = `ALUC_INC;     writes_reg = 1'b1; end
            OP_SETP:  aluc_c = `ALUC_EQ;
            OP_LOAD:  begin s2_c = `MuxD_fromMem; writes_reg = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_data;
                state_d = (imem_data[31:28] == OP_HALT) ? S_HALTED : S_EXE;
            end
            S_EXE:    state_d = (op == OP_LOAD) ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = take_branch ? ir_q[PC_WIDTH-1:0] : pc_q + PC_WIDTH'(1);
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes are decoded from the state register, so reset kills a pending write-back at once.
    assign imem_addr = pc_q;
    assign x         = ir_q[27:24];
    assign y         = ir_q[23:20];
    assign z         = ir_q[19:16];
    assign I         = ir_q[15:0];
    assign aluc      = aluc_c;
    assign s2        = s2_c;
    assign reg_we    = (state_q == S_WB) && writes_reg;
    assign mem_we    = (state_q == S_WB) && (op == OP_STORE);
    assign en        = (state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign done      = (state_q == S_HALTED);

endmodule

// File: tb/tb_sm_control_unit.sv
// tb/tb_sm_control_unit.sv - self-checking bench for sm_control_unit against an instruction-level model
`ifndef ALUC_NONE
`define ALUC_NONE    4'd0
`define ALUC_ADD     4'd1
`define ALUC_MUL     4'd2
`define ALUC_MAD     4'd3
`define ALUC_CORE_ID 4'd4
`define ALUC_CLEAR   4'd5
`define ALUC_INC     4'd6
`define ALUC_EQ      4'd7
`endif
`ifndef MuxD_fromALU
`define MuxD_fromALU 2'd0
`define MuxD_fromI   2'd1
`define MuxD_fromMem 2'd2
`endif

module tb_sm_control_unit;
    logic clk = 1'b0;
    logic reset, start, start2, p_in, core_clr;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [3:0]  x, y, z, aluc;
    logic [15:0] I;
    logic [1:0]  s2;
    logic reg_we, en, mem_we, busy, done;
    logic [1:0]  addr2;
    logic [3:0]  x2, y2, z2, aluc2;
    logic [15:0] i2;
    logic [1:0]  s2_2;
    logic reg_we2, en2, mem_we2, busy2, done2;

    logic [31:0] imem [256];
    logic [15:0] regs [16];
    logic [15:0] dmem [256];

    int n_assert = 0;
    int n_fail = 0;
    int tr_k, tr_done, tr_we;
    int d_idx, w_cnt;

    always #5 clk = ~clk;

    sm_control_unit #(.PC_WIDTH(8), .INSTR_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2), .reg_we(reg_we), .en(en),
        .mem_we(mem_we), .p_in(p_in), .busy(busy), .done(done));

    sm_control_unit #(.PC_WIDTH(2), .INSTR_WIDTH(32)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .imem_addr(addr2), .imem_data(32'h0),
        .x(x2), .y(y2), .z(z2), .I(i2), .aluc(aluc2), .s2(s2_2), .reg_we(reg_we2), .en(en2),
        .mem_we(mem_we2), .p_in(1'b0), .busy(busy2), .done(done2));

    always @(posedge clk) imem_data <= imem[imem_addr];

    // Minimal SPCore stand-in so register results of programs can be checked.
    function automatic logic [15:0] core_val(input logic [1:0] sel, input logic [3:0] op_c,
                                             input logic [15:0] rx, input logic [15:0] ry,
                                             input logic [15:0] rz, input logic [15:0] imm,
                                             input logic [15:0] mval);
        if (sel == `MuxD_fromI) return imm;
        if (sel == `MuxD_fromMem) return mval;
        case (op_c)
            `ALUC_ADD: return ry + rz;
            `ALUC_MUL: return ry * rz;
            `ALUC_MAD: return ry * rz + rx;
            `ALUC_INC: return rx + 16'd1;
            default:   return 16'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (core_clr) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
        end else if (!reset) begin
            if (reg_we) regs[x] <= core_val(s2, aluc, regs[x], regs[y], regs[z], I, dmem[I[7:0]]);
            if (mem_we) dmem[I[7:0]] <= regs[x];
        end
    end

    function automatic logic [3:0] m_aluc(input logic [3:0] op);
        case (op)
            4'd2: return `ALUC_ADD;
            4'd3: return `ALUC_MUL;
            4'd4: return `ALUC_MAD;
            4'd5: return `ALUC_CORE_ID;
            4'd6: return `ALUC_CLEAR;
            4'd7: return `ALUC_INC;
            4'd8: return `ALUC_EQ;
            default: return `ALUC_NONE;
        endcase
    endfunction

    function automatic logic [1:0] m_s2(input logic [3:0] op);
        if (op == 4'd1) return `MuxD_fromI;
        if (op == 4'd10) return `MuxD_fromMem;
        return `MuxD_fromALU;
    endfunction

    function automatic bit m_wr(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd7) || op == 4'd10;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [12:0] exp_ctrl, input bit dchk,
                        input logic [33:0] exp_data);
        chk({tag, "_ctrl"}, 64'({imem_addr, reg_we, en, mem_we, busy, done}), 64'(exp_ctrl));
        if (dchk) chk({tag, "_bus"}, 64'({x, y, z, I, aluc, s2}), 64'(exp_data));
        if (done === 1'b1 && tr_done < 0) tr_done = tr_k;
        if (reg_we === 1'b1) tr_we++;
        tr_k++;
        @(negedge clk);
    endtask

    // Walks the program at instruction level: each op is FETCH+DECODE then 2 (or 3 for LOAD) bus cycles.
    task automatic run_prog(input int max_instr, output int done_idx, output int we_cnt);
        logic [7:0] pc;
        logic [31:0] w;
        logic [3:0] op;
        int len;
        bit fin;
        pc = 8'd0; fin = 1'b0; tr_k = 0; tr_done = -1; tr_we = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < max_instr && !fin; n++) begin
            w = imem[pc];
            op = w[31:28];
            if (op == 4'hF) begin
                step($sformatf("i%0d_fetch", n), {pc, 5'b00010}, 1'b0, 34'd0);
                step($sformatf("i%0d_decode", n), {pc, 5'b00010}, 1'b0, 34'd0);
                step($sformatf("i%0d_halted", n), {pc, 5'b00001}, 1'b0, 34'd0);
                fin = 1'b1;
            end else begin
                len = (op == 4'd10) ? 5 : 4;
                for (int c = 0; c < len; c++) begin
                    step($sformatf("i%0d_c%0d", n, c),
                         {pc, (c == len - 1) && m_wr(op), c >= 2, (c == len - 1) && (op == 4'd9), 2'b10},
                         c >= 2, {w[27:0], m_aluc(op), m_s2(op)});
                end
                pc = pc + 8'd1;
`ifdef SM_BRANCH_EN
                if (op == 4'd11 || (op == 4'd12 && p_in)) pc = w[7:0];
`endif
            end
        end
        done_idx = tr_done;
        we_cnt = tr_we;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_core();
        core_clr = 1'b1;
        @(negedge clk);
        core_clr = 1'b0;
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
        imem[0] = 32'h1000_000B;
        imem[1] = 32'h1100_0014;
        imem[2] = 32'h2201_0000;
    endtask

    initial begin
        logic [7:0] exp_addr;
        reset = 1'b1; start = 1'b0; start2 = 1'b0; p_in = 1'b0; core_clr = 1'b0;
        for (int i = 0; i < 256; i++) begin imem[i] = 32'hF000_0000; dmem[i] = 16'd0; end
        @(negedge clk);
        chk("reset_outs", 64'({imem_addr, x, y, z, I, aluc, s2, reg_we, en, mem_we, busy, done}),
            64'({8'd0, 28'd0, `ALUC_NONE, `MuxD_fromALU, 5'd0}));
        chk("reset_outs2", 64'({addr2, busy2, done2, en2}), 64'd0);
        clear_core();
        reset = 1'b0;

        load_prog_a();
        run_prog(10, d_idx, w_cnt);
        chk("a_done_latency", 64'(d_idx), 64'd14);
        chk("a_reg_we_pulses", 64'(w_cnt), 64'd3);
        chk("a_r2", 64'(regs[2]), 64'd31);
        @(negedge clk); start = 1'b0;
        chk("a_done_hold", 64'({busy, done}), 64'b01);

        imem[3] = 32'h4201_0000;
        run_prog(10, d_idx, w_cnt);
        chk("b_done_latency", 64'(d_idx), 64'd18);
        chk("b_r2", 64'(regs[2]), 64'd251);

        for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
        imem[0] = 32'h1400_005A;
        imem[1] = 32'h9400_0007;
        imem[2] = 32'hA300_0007;
        run_prog(10, d_idx, w_cnt);
        chk("sl_done_latency", 64'(d_idx), 64'd15);
        chk("sl_reg_we_pulses", 64'(w_cnt), 64'd2);
        chk("sl_r3", 64'(regs[3]), 64'h5A);

        load_prog_a();
        do_reset();
        clear_core();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_exe_bus", 64'({en, x, y, z, aluc}), 64'({1'b1, 12'h201, `ALUC_ADD}));
        #1 reset = 1'b1;
        #1 chk("async_reset_outs", 64'({imem_addr, x, y, z, I, aluc, s2, reg_we, en, mem_we, busy, done}),
               64'({8'd0, 28'd0, `ALUC_NONE, `MuxD_fromALU, 5'd0}));
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_we", 64'({reg_we, mem_we, en}), 64'd0);
        end
        reset = 1'b0;
        chk("reset_r2_untouched", 64'(regs[2]), 64'd0);
        chk("reset_r0_kept", 64'(regs[0]), 64'd11);
        run_prog(10, d_idx, w_cnt);
        chk("rerun_done_latency", 64'(d_idx), 64'd14);
        chk("rerun_r2", 64'(regs[2]), 64'd31);

        for (int pv = 1; pv >= 0; pv--) begin
            for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
            imem[0] = 32'h8011_0000;
            imem[1] = 32'hC000_0005;
            p_in = pv[0];
            run_prog(10, d_idx, w_cnt);
`ifdef SM_BRANCH_EN
            exp_addr = pv[0] ? 8'd5 : 8'd2;
`else
            exp_addr = 8'd2;
`endif
            chk($sformatf("brp_target_p%0d", pv), 64'(imem_addr), 64'(exp_addr));
            chk($sformatf("brp_no_we_p%0d", pv), 64'(w_cnt), 64'd0);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(14, 0)), 28'($urandom)};
            p_in = 1'($urandom);
            run_prog(25, d_idx, w_cnt);
            do_reset();
        end

        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("pc2_k%0d", k),
                64'({addr2, busy2, done2, en2, x2, y2, z2, i2, aluc2, s2_2, reg_we2, mem_we2}),
                64'({2'((k / 4) % 4), 1'b1, 1'b0, (k % 4) >= 2, 28'd0, `ALUC_NONE, `MuxD_fromALU, 2'b00}));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
